// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : Iterative 32-bit radix-2 restoring divider for the execute
//               stage (RV32M DIV/DIVU/REM/REMU). One quotient bit per cycle,
//               one division in flight, one-cycle ready pulse on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);

    localparam logic [2:0] C_OP_DIV  = 3'b100;
    localparam logic [2:0] C_OP_REM  = 3'b110;
    localparam logic [2:0] C_OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] dvd_q;       // dividend shifting out, quotient shifting in
    logic [31:0] dvsr_q;      // divisor magnitude
    logic [31:0] rem_q;       // partial remainder
    logic [4:0]  cnt_q;
    logic        is_rem_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic        start_signed_d;
    logic        start_rem_d;
    logic [31:0] dvd_mag_d;
    logic [31:0] dvsr_mag_d;
    logic [32:0] rem_shift_d;
    logic [32:0] rem_sub_d;
    logic        qbit_d;
    logic [31:0] rem_d;
    logic [31:0] quot_fin_d;
    logic [31:0] rem_fin_d;
    logic [31:0] result_d;

    // Operand decode, one restoring iteration, and final sign fix-up.
    always_comb begin
        start_signed_d = (op_i == C_OP_DIV) || (op_i == C_OP_REM);
        start_rem_d    = (op_i == C_OP_REM) || (op_i == C_OP_REMU);
        dvd_mag_d      = (start_signed_d && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
        dvsr_mag_d     = (start_signed_d && divisor_i[31])  ? (~divisor_i + 32'd1)  : divisor_i;

        // Remainder is always below the divisor, so 33 bits cover the shifted value.
        rem_shift_d    = {rem_q, dvd_q[31]};
        rem_sub_d      = rem_shift_d - {1'b0, dvsr_q};
        qbit_d         = (rem_shift_d >= {1'b0, dvsr_q});
        rem_d          = qbit_d ? rem_sub_d[31:0] : rem_shift_d[31:0];

        quot_fin_d     = neg_quot_q ? (~dvd_q + 32'd1) : dvd_q;
        rem_fin_d      = neg_rem_q  ? (~rem_q + 32'd1) : rem_q;
        result_d       = is_rem_q ? rem_fin_d : quot_fin_d;
    end

    // Control FSM with datapath and registered outputs; flush beats start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= 32'd0;
            dvsr_q      <= 32'd0;
            rem_q       <= 32'd0;
            cnt_q       <= 5'd0;
            is_rem_q    <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_o    <= 32'd0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= 5'd0;
        end else begin
            ready_o <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            is_rem_q    <= start_rem_d;
                            reg_waddr_o <= reg_waddr_i;
                            busy_o      <= 1'b1;
                            cnt_q       <= 5'd0;
                            if (divisor_i != 32'd0) begin
                                dvd_q      <= dvd_mag_d;
                                dvsr_q     <= dvsr_mag_d;
                                rem_q      <= 32'd0;
                                neg_quot_q <= start_signed_d && (dividend_i[31] ^ divisor_i[31]);
                                neg_rem_q  <= start_signed_d && dividend_i[31];
                                state_q    <= S_CALC;
                            end else begin
                                // Divide by zero: preload the final answer and skip iteration.
                                dvd_q      <= 32'hFFFF_FFFF;
                                dvsr_q     <= 32'd0;
                                rem_q      <= dividend_i;
                                neg_quot_q <= 1'b0;
                                neg_rem_q  <= 1'b0;
                                state_q    <= S_END;
                            end
                        end
                    end
                    S_CALC: begin
                        dvd_q <= {dvd_q[30:0], qbit_d};
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= S_END;
                        end
                    end
                    S_END: begin
                        result_o <= result_d;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div
// Description : Scoreboard bench for ex_div: driver pushes expected results,
//               negedge monitor pops and compares on every ready_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [2:0]  op_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .op_i       (op_i),
        .reg_waddr_i(reg_waddr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned start_cyc;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M division semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b100:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b110:  ref_div = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            3'b111:  ref_div = (b == 0) ? a : a % b;
            default: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && ready_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got result 0x%08h with no request outstanding", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_result"}, result_o, e.res);
                chk({e.name, "_rd"}, {27'd0, reg_waddr_o}, {27'd0, e.rd});
                chk({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
                chk({e.name, "_busy_at_ready"}, {31'd0, busy_o}, 32'd0);
            end
        end
    end

    // Drive one operation starting at the current negedge; returns at the ready negedge.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit poke_busy);
        exp_t e;
        int   n;
        e.res       = ref_div(op, a, b);
        e.rd        = rd;
        e.start_cyc = cyc;
        e.lat       = (b == 0) ? 2 : 34;
        e.name      = name;
        exp_q.push_back(e);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        @(negedge clk);
        start_i = 1'b0;
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd1);
        n = 0;
        while (!ready_o && n < 40) begin
            if (poke_busy && n == 5) begin
                start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ready_o after %0d cycles, required within 40", name, n);
        end
    endtask

    task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       rnd_operand = 32'h8000_0000;
            1:       rnd_operand = 32'hFFFF_FFFF;
            2:       rnd_operand = 32'd0;
            3:       rnd_operand = $urandom_range(0, 20);
            4:       rnd_operand = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: rnd_operand = $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        dividend_i = 32'd0; divisor_i = 32'd0; op_i = 3'd0; reg_waddr_i = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_result", result_o, 32'd0);
        chk("reset_ready", {31'd0, ready_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_rd", {27'd0, reg_waddr_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases, issued back-to-back on each ready cycle.
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 1'b0);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd6, 1'b0);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
        do_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9, 1'b0);
        do_op("div_5_0",    3'b100, 32'd5, 32'd0, 5'd10, 1'b0);
        do_op("remu_x_0",   3'b111, 32'h1234, 32'd0, 5'd11, 1'b0);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
        @(negedge clk);

        // Flush in the middle of CALC: no pulse, busy drops, result held.
        start_only(3'b101, 32'd77, 32'd5, 5'd20);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_ready", {31'd0, ready_o}, 32'd0);
        chk("flush_result_held", result_o, ref_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF));
        repeat (40) @(negedge clk);
        do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd14, 1'b0);
        @(negedge clk);

        // Start while busy must be ignored.
        do_op("busy_start_ignored", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd15, 1'b1);
        repeat (40) @(negedge clk);

        // Reset in the middle of CALC.
        start_only(3'b100, 32'd12345, 32'd17, 5'd21);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_result", result_o, 32'd0);
        chk("midreset_busy", {31'd0, busy_o}, 32'd0);
        chk("midreset_rd", {27'd0, reg_waddr_o}, 32'd0);
        chk("midreset_ready", {31'd0, ready_o}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized traffic with random idle gaps (zero gap = back-to-back).
        for (int i = 0; i < 70; i++) begin
            do_op("rand", 3'($urandom), rnd_operand(), rnd_operand(), 5'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding: %0d results never returned, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
